// File: rtl/line_mem_responder_if.sv
// line_mem_responder_if
// Line-fill / write-back request bus between a cache (master) and its
// backing store (slave).
//   mem_req_valid  master->slave  request pending, held until ready pulse
//   mem_req_wr     master->slave  1 = write line, 0 = read line
//   mem_req_addr   master->slave  byte address, bits [3:0] ignored
//   mem_wr_data    master->slave  write line
//   mem_rd_data    slave->master  read line, valid in the ready cycle
//   mem_req_ready  slave->master  one-cycle completion pulse
interface line_mem_responder_if #(
    parameter int ADDR_W = 17,
    parameter int LINE_W = 128
);
    logic              mem_req_valid;
    logic              mem_req_wr;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [LINE_W-1:0] mem_wr_data;
    logic [LINE_W-1:0] mem_rd_data;
    logic              mem_req_ready;

    modport master (
        output mem_req_valid,
        output mem_req_wr,
        output mem_req_addr,
        output mem_wr_data,
        input  mem_rd_data,
        input  mem_req_ready
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_wr,
        input  mem_req_addr,
        input  mem_wr_data,
        output mem_rd_data,
        output mem_req_ready
    );
endinterface

// File: rtl/line_mem_responder.sv
// line_mem_responder
// Fixed-latency backing store answering one 128-bit line read or write at a
// time on the cache line-fill/write-back port. Completion is a one-cycle
// mem_req_ready pulse LATENCY cycles after the request is accepted.
//
// Ports
//   clk       clock, all state on posedge
//   rst       asynchronous reset, active-high
//   bus       line_mem_responder_if.slave (request/response bus)
//   busy      1 while a transaction is in flight (BUSY or RESP)
//   rd_count  completed reads, saturating   (LINE_MEM_RESPONDER_STATS_EN only)
//   wr_count  completed writes, saturating  (LINE_MEM_RESPONDER_STATS_EN only)
//
// Optional feature macro: LINE_MEM_RESPONDER_STATS_EN
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for mem_req_valid; request fields latched on acceptance
// BUSY  | latency countdown; abort to IDLE if mem_req_valid drops
// RESP  | ready pulse; read data presented, write committed at cycle end
module line_mem_responder #(
    parameter int          ADDR_W    = 17,
    parameter int          LINE_W    = 128,
    parameter int          LINES     = 1024,
    parameter int          LATENCY   = 3,
    parameter logic [31:0] INIT_WORD = 32'hDEADBEEF
) (
    input  logic                 clk,
    input  logic                 rst,
    line_mem_responder_if.slave  bus,
    output logic                 busy
`ifdef LINE_MEM_RESPONDER_STATS_EN
    ,
    output logic [15:0]          rd_count,
    output logic [15:0]          wr_count
`endif
);

    localparam int IDX_W = $clog2(LINES);
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [7:0]         r_cnt;
    logic               r_wr;
    logic [IDX_W-1:0]   r_idx;
    logic [LINE_W-1:0]  r_wdata;
    logic [LINE_W-1:0]  r_rd_data;
    logic               r_ready;

    logic               w_accept;
    logic               w_to_resp;
    logic               w_dec;
    logic [IDX_W-1:0]   w_idx;

    // Power-up contents; reset never touches the array.
    logic [LINE_W-1:0]  r_mem [LINES] = '{default: {(LINE_W/32){INIT_WORD}}};

    // Upper address bits are dropped so addresses alias modulo LINES.
    assign w_idx = bus.mem_req_addr[4 +: IDX_W];

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_to_resp    = 1'b0;
        w_dec        = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.mem_req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = BUSY;
                end
            end
            BUSY: begin
                if (!bus.mem_req_valid) begin
                    w_next_state = IDLE;
                end else if (r_cnt == 8'd0) begin
                    w_to_resp    = 1'b1;
                    w_next_state = RESP;
                end else begin
                    w_dec = 1'b1;
                end
            end
            RESP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= 8'd0;
            r_wr      <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_rd_data <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ready <= w_to_resp;
            if (w_accept) begin
                r_wr    <= bus.mem_req_wr;
                r_idx   <= w_idx;
                r_wdata <= bus.mem_wr_data;
                r_cnt   <= CNT_INIT;
            end else if (w_dec) begin
                r_cnt <= r_cnt - 8'd1;
            end
            if (w_to_resp && !r_wr) begin
                r_rd_data <= r_mem[r_idx];
            end
        end
    end

    // A reset during RESP forces r_state to IDLE asynchronously, so the
    // write below cannot fire for a discarded transaction.
    always_ff @(posedge clk) begin
        if (r_state == RESP && r_wr) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign bus.mem_rd_data   = r_rd_data;
    assign bus.mem_req_ready = r_ready;
    assign busy              = (r_state != IDLE);

`ifdef LINE_MEM_RESPONDER_STATS_EN
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_count <= 16'd0;
            r_wr_count <= 16'd0;
        end else if (r_state == RESP) begin
            if (r_wr) begin
                if (r_wr_count != 16'hFFFF) r_wr_count <= r_wr_count + 16'd1;
            end else begin
                if (r_rd_count != 16'hFFFF) r_rd_count <= r_rd_count + 16'd1;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
module tb_line_mem_responder;
    localparam int          LAT   = 3;
    localparam int          NLINE = 1024;
    localparam logic [31:0] INITW = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst;
    logic busy;
`ifdef LINE_MEM_RESPONDER_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
`endif

    always #5 clk = ~clk;

    line_mem_responder_if #(.ADDR_W(17), .LINE_W(128)) bus ();

    line_mem_responder #(
        .ADDR_W(17), .LINE_W(128), .LINES(NLINE), .LATENCY(LAT), .INIT_WORD(INITW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .busy(busy)
`ifdef LINE_MEM_RESPONDER_STATS_EN
        ,
        .rd_count(rd_count),
        .wr_count(wr_count)
`endif
    );

    int total = 0;
    int bad   = 0;
    logic [127:0] model [NLINE];
    int exp_rd = 0;
    int exp_wr = 0;
    logic [127:0] init_line;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int line_of(input logic [16:0] addr);
        return (int'(addr) / 16) % NLINE;
    endfunction

    // Complete transaction; request inputs are scrambled during BUSY
    // (valid kept high) to show the fields were captured at acceptance.
    task automatic xact(input bit wr, input logic [16:0] addr, input logic [127:0] data);
        int cyc;
        bit got;
        logic [127:0] exp;
        int idx;
        idx = line_of(addr);
        exp = model[idx];
        @(negedge clk);
        bus.mem_req_valid = 1'b1;
        bus.mem_req_wr    = wr;
        bus.mem_req_addr  = addr;
        bus.mem_wr_data   = data;
        @(posedge clk);
        #1;
        bus.mem_req_wr   = ~wr;
        bus.mem_req_addr = 17'($urandom);
        bus.mem_wr_data  = ~data;
        cyc = 0;
        got = 0;
        while (!got && cyc < 300) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.mem_req_ready === 1'b1) got = 1;
        end
        check("ready_seen", 128'(got), 128'd1);
        check("latency", 128'(cyc), 128'(LAT));
        check("busy_in_resp", 128'(busy), 128'd1);
        if (!wr) check("rd_data", bus.mem_rd_data, exp);
        bus.mem_req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("ready_width", 128'(bus.mem_req_ready), 128'd0);
        check("busy_after", 128'(busy), 128'd0);
        if (!wr) check("rd_hold", bus.mem_rd_data, exp);
        if (wr) begin
            model[idx] = data;
            exp_wr++;
        end else begin
            exp_rd++;
        end
    endtask

    // Request dropped in the second BUSY cycle: no ready, no write.
    task automatic aborted(input bit wr, input logic [16:0] addr, input logic [127:0] data);
        int pulses;
        @(negedge clk);
        bus.mem_req_valid = 1'b1;
        bus.mem_req_wr    = wr;
        bus.mem_req_addr  = addr;
        bus.mem_wr_data   = data;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.mem_req_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.mem_req_ready === 1'b1) pulses++;
        end
        check("abort_no_ready", 128'(pulses), 128'd0);
        check("abort_idle", 128'(busy), 128'd0);
    endtask

    initial begin
        init_line = {4{INITW}};
        for (int i = 0; i < NLINE; i++) model[i] = init_line;
        bus.mem_req_valid = 1'b0;
        bus.mem_req_wr    = 1'b0;
        bus.mem_req_addr  = '0;
        bus.mem_wr_data   = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 128'(bus.mem_req_ready), 128'd0);
        check("rst_rd_data", bus.mem_rd_data, 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        @(negedge clk);
        rst = 1'b0;

        xact(1'b0, 17'h0FADE, 128'd0);
        check("init_pattern", model[line_of(17'h0FADE)], init_line);
        xact(1'b1, 17'h0DAFE, {4{32'hFEEDDEAD}});
        xact(1'b0, 17'h0DAFE, 128'd0);
        xact(1'b1, 17'h00010, {32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888});
        xact(1'b0, 17'h04010, 128'd0);
        aborted(1'b1, 17'h00020, {4{32'hBADBAD00}});
        xact(1'b0, 17'h00020, 128'd0);

        // Reset in the middle of a write's BUSY phase.
        @(negedge clk);
        bus.mem_req_valid = 1'b1;
        bus.mem_req_wr    = 1'b1;
        bus.mem_req_addr  = 17'h00030;
        bus.mem_wr_data   = {4{32'hC0FFEE00}};
        @(posedge clk);
        @(posedge clk);
        #1;
        check("pre_rst_busy", 128'(busy), 128'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 128'(bus.mem_req_ready), 128'd0);
        check("mid_rst_rd_data", bus.mem_rd_data, 128'd0);
        check("mid_rst_busy", 128'(busy), 128'd0);
        bus.mem_req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_rd = 0;
        exp_wr = 0;
        xact(1'b0, 17'h00030, 128'd0);

        for (int n = 0; n < 40; n++) begin
            logic [16:0] a;
            logic [127:0] d;
            bit w;
            a = 17'($urandom) & 17'h1C07F;
            d = {$urandom, $urandom, $urandom, $urandom};
            w = 1'($urandom);
            if ($urandom_range(0, 7) == 0) aborted(w, a, d);
            else xact(w, a, d);
        end

`ifdef LINE_MEM_RESPONDER_STATS_EN
        check("rd_count", 128'(rd_count), 128'(exp_rd));
        check("wr_count", 128'(wr_count), 128'(exp_wr));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
